// File: rtl/imem_resp_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | imem_resp_ctrl                                                         |
// | Fetch responder: 1-cycle ITCM path (IMEM_ITCM_EN) and req/gnt/rvalid   |
// | instruction-bus FSM; responses made stale by a redirect are dropped.   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module imem_resp_ctrl #(
  parameter logic [31:0] ITCM_BASE      = 32'h0000_0000,
  parameter int          ITCM_SIZE_LOG2 = 16,
  parameter int          ITCM_AW        = 14
) (
  input  logic               cpu_clk,
  input  logic               cpu_rstn,
  input  logic [31:0]        next_pc,
  output logic               instr_read_data_valid,
  output logic [31:0]        instr_read_data,
  output logic               instr_access_fault,
  output logic               itcm_cs,
  output logic [ITCM_AW-1:0] itcm_addr,
  input  logic [31:0]        itcm_rdata,
  output logic               ibus_req,
  output logic [31:0]        ibus_addr,
  input  logic               ibus_gnt,
  input  logic               ibus_rvalid,
  input  logic [31:0]        ibus_rdata,
  input  logic               ibus_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUS_REQ  = 2'd1,
    BUS_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:2] r_req_addr;
  logic [31:0] r_bus_rdata;
  logic        r_bus_hit;
  logic        r_err_q;
  logic        r_stale;
  logic        w_stale_nxt;
  logic        w_accept;
  logic        w_itcm_hit;
  logic        w_redirect;
  logic        w_unused;

`ifdef IMEM_ITCM_EN
  logic r_itcm_pend;

  assign w_itcm_hit = (next_pc[31:ITCM_SIZE_LOG2] == ITCM_BASE[31:ITCM_SIZE_LOG2]);
  assign itcm_cs    = (r_state == IDLE) && w_itcm_hit;
  assign itcm_addr  = next_pc[ITCM_SIZE_LOG2-1:2];
  assign w_unused   = ^{next_pc[1:0], ITCM_BASE};

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_itcm_pend <= 1'b0;
    end else begin
      r_itcm_pend <= itcm_cs;
    end
  end

  assign instr_read_data_valid = r_itcm_pend | r_bus_hit;
  assign instr_read_data       = r_itcm_pend ? itcm_rdata :
                                 (r_bus_hit ? r_bus_rdata : 32'h0);
`else
  assign w_itcm_hit = 1'b0;
  assign itcm_cs    = 1'b0;
  assign itcm_addr  = '0;
  assign w_unused   = ^{next_pc[1:0], itcm_rdata, ITCM_BASE, 32'(ITCM_SIZE_LOG2)};

  assign instr_read_data_valid = r_bus_hit;
  assign instr_read_data       = r_bus_hit ? r_bus_rdata : 32'h0;
`endif

  assign instr_access_fault = r_bus_hit & r_err_q;
  assign ibus_addr          = {r_req_addr, 2'b00};
  // Any change of the fetch word while a bus fetch is in flight is a redirect
  assign w_redirect         = (next_pc[31:2] != r_req_addr);

  always_comb begin
    w_state_nxt = r_state;
    w_stale_nxt = r_stale;
    w_accept    = 1'b0;
    ibus_req    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_itcm_hit) begin
          w_state_nxt = BUS_REQ;
        end
      end
      BUS_REQ: begin
        ibus_req = 1'b1;
        if (w_redirect) begin
          w_stale_nxt = 1'b1;
        end
        if (ibus_gnt) begin
          w_state_nxt = BUS_WAIT;
        end
      end
      BUS_WAIT: begin
        if (w_redirect) begin
          w_stale_nxt = 1'b1;
        end
        if (ibus_rvalid) begin
          w_accept    = !r_stale && !w_redirect;
          w_stale_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_state     <= IDLE;
      r_stale     <= 1'b0;
      r_req_addr  <= '0;
      r_bus_hit   <= 1'b0;
      r_bus_rdata <= 32'h0;
      r_err_q     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_stale   <= w_stale_nxt;
      r_bus_hit <= w_accept;
      if ((r_state == IDLE) && !w_itcm_hit) begin
        r_req_addr <= next_pc[31:2];
      end
      if (w_accept) begin
        r_bus_rdata <= ibus_rdata;
        r_err_q     <= ibus_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_resp_ctrl.sv
`default_nettype none
// tb_imem_resp_ctrl: directed fetch sequences; a scoreboard monitor checks
// every presented response for data, fault and arrival cycle.
module tb_imem_resp_ctrl;

  localparam int ITCM_AW = 14;
`ifdef IMEM_ITCM_EN
  localparam logic [31:0] RDIR = 32'h0000_0040;
`else
  localparam logic [31:0] RDIR = 32'h8000_0040;
`endif

  logic               cpu_clk = 1'b0;
  logic               cpu_rstn = 1'b0;
  logic [31:0]        next_pc = 32'h0;
  logic               instr_read_data_valid;
  logic [31:0]        instr_read_data;
  logic               instr_access_fault;
  logic               itcm_cs;
  logic [ITCM_AW-1:0] itcm_addr;
  logic [31:0]        itcm_rdata = 32'h0;
  logic               ibus_req;
  logic [31:0]        ibus_addr;
  logic               ibus_gnt = 1'b0;
  logic               ibus_rvalid = 1'b0;
  logic [31:0]        ibus_rdata = 32'h0;
  logic               ibus_err = 1'b0;

  imem_resp_ctrl dut (
    .cpu_clk               (cpu_clk),
    .cpu_rstn              (cpu_rstn),
    .next_pc               (next_pc),
    .instr_read_data_valid (instr_read_data_valid),
    .instr_read_data       (instr_read_data),
    .instr_access_fault    (instr_access_fault),
    .itcm_cs               (itcm_cs),
    .itcm_addr             (itcm_addr),
    .itcm_rdata            (itcm_rdata),
    .ibus_req              (ibus_req),
    .ibus_addr             (ibus_addr),
    .ibus_gnt              (ibus_gnt),
    .ibus_rvalid           (ibus_rvalid),
    .ibus_rdata            (ibus_rdata),
    .ibus_err              (ibus_err)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc_n = 0;

  always @(posedge cpu_clk) cyc_n <= cyc_n + 1;

  // ITCM model: word contents tagged with their own word address
  always @(posedge cpu_clk) itcm_rdata <= itcm_cs ? {itcm_addr, 18'h00013} : 32'hBAD0_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  always @(negedge cpu_clk) begin
    if (instr_read_data_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid actual=1 data=%h expected=no response (cycle %0d)",
                 instr_read_data, cyc_n);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_data", instr_read_data, mon_e.data);
        chk("rsp_fault", 32'(instr_access_fault), 32'(mon_e.fault));
        chk("rsp_cycle", 32'(cyc_n), 32'(mon_e.cyc));
      end
    end else begin
      chk("idle_data", instr_read_data, 32'h0);
      chk("idle_fault", 32'(instr_access_fault), 32'h0);
    end
`ifndef IMEM_ITCM_EN
    chk("itcm_cs_off", 32'(itcm_cs), 32'h0);
    chk("itcm_addr_off", 32'(itcm_addr), 32'h0);
`endif
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  // Bus fetch starting in IDLE: gw cycles without gnt, rw cycles without rvalid
  task automatic bus_fetch(input logic [31:0] addr, input int gw, input int rw,
                           input logic [31:0] data, input logic err);
    exp_t e;
    next_pc = addr;
    e.data = data;
    e.fault = err;
    e.cyc = cyc_n + 3 + gw + rw;
    sb.push_back(e);
    tick();
    for (int i = 0; i <= gw; i++) begin
      ibus_gnt = (i == gw);
      ibus_rvalid = (i == 0) && (gw > 0);
      ibus_rdata = 32'hBADB_AD00;
      ibus_err = 1'b1;
      @(negedge cpu_clk);
      chk("req_held", 32'(ibus_req), 32'h1);
      chk("req_addr", ibus_addr, {addr[31:2], 2'b00});
      tick();
    end
    ibus_gnt = 1'b0;
    for (int i = 0; i <= rw; i++) begin
      ibus_rvalid = (i == rw);
      ibus_rdata = (i == rw) ? data : 32'h0;
      ibus_err = (i == rw) ? err : 1'b0;
      @(negedge cpu_clk);
      chk("req_wait_low", 32'(ibus_req), 32'h0);
      tick();
    end
    ibus_rvalid = 1'b0;
    ibus_err = 1'b0;
    ibus_rdata = 32'h0;
  endtask

`ifdef IMEM_ITCM_EN
  task automatic itcm_fetch(input logic [31:0] addr);
    exp_t e;
    next_pc = addr;
    e.data = {addr[15:2], 18'h00013};
    e.fault = 1'b0;
    e.cyc = cyc_n + 1;
    sb.push_back(e);
    @(negedge cpu_clk);
    chk("itcm_cs", 32'(itcm_cs), 32'h1);
    chk("itcm_addr", 32'(itcm_addr), 32'(addr[15:2]));
    tick();
  endtask
`endif

  task automatic fetch_x(input logic [31:0] addr, input logic [31:0] data);
`ifdef IMEM_ITCM_EN
    itcm_fetch(addr);
`else
    bus_fetch(addr, 0, 0, data, 1'b0);
`endif
  endtask

  // Redirected bus fetch whose response must be dropped.
  // mode 0: redirect in BUS_WAIT, back before rvalid; 1: redirect with rvalid;
  // mode 2: redirect in BUS_REQ, back before rvalid.
  task automatic drop_fetch(input logic [31:0] addr, input logic [31:0] x, input int mode);
    next_pc = addr;
    tick();
    if (mode == 2) next_pc = x;
    ibus_gnt = 1'b1;
    @(negedge cpu_clk);
    chk("drop_req", 32'(ibus_req), 32'h1);
    chk("drop_addr_held", ibus_addr, {addr[31:2], 2'b00});
    tick();
    ibus_gnt = 1'b0;
    next_pc = addr;
    if (mode == 0) begin
      next_pc = x;
      tick();
      next_pc = addr;
    end
    if (mode == 1) next_pc = x;
    ibus_rvalid = 1'b1;
    ibus_rdata = 32'hDEAD_0BAD;
    tick();
    ibus_rvalid = 1'b0;
    ibus_rdata = 32'h0;
  endtask

  task automatic mid_reset(input logic [31:0] addr);
    next_pc = addr;
    tick();
    @(negedge cpu_clk);
    chk("mr_req_before", 32'(ibus_req), 32'h1);
    #2;
    cpu_rstn = 1'b0;
    #1;
    chk("mr_req_async", 32'(ibus_req), 32'h0);
    chk("mr_addr_async", ibus_addr, 32'h0);
    chk("mr_valid_async", 32'(instr_read_data_valid), 32'h0);
    tick();
    tick();
    cpu_rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    chk("rst_valid", 32'(instr_read_data_valid), 32'h0);
    chk("rst_data", instr_read_data, 32'h0);
    chk("rst_fault", 32'(instr_access_fault), 32'h0);
    chk("rst_req", 32'(ibus_req), 32'h0);
    chk("rst_addr", ibus_addr, 32'h0);
    tick();
    cpu_rstn = 1'b1;

`ifdef IMEM_ITCM_EN
    itcm_fetch(32'h0000_0000);
    itcm_fetch(32'h0000_0004);
    itcm_fetch(32'h0000_0008);
    itcm_fetch(32'h0000_0008);
`else
    bus_fetch(32'h0000_0000, 0, 0, 32'h0000_0013, 1'b0);
    bus_fetch(32'h0000_0004, 0, 0, 32'h0010_0093, 1'b0);
`endif
    bus_fetch(32'h8000_0100, 0, 1, 32'h0040_0093, 1'b0);
    bus_fetch(32'h8000_0104, 1, 0, 32'hDEAD_BEEF, 1'b1);
    bus_fetch(32'h8000_0108, 5, 2, 32'h1234_5678, 1'b0);
    bus_fetch(32'h8000_0108, 0, 0, 32'h1234_5679, 1'b0);
    bus_fetch(32'h8000_0602, 2, 0, 32'h0000_6F00, 1'b0);

    drop_fetch(32'h8000_0300, RDIR, 0);
    fetch_x(RDIR, 32'hA000_0001);
    drop_fetch(32'h8000_0304, RDIR + 32'h4, 1);
    fetch_x(RDIR + 32'h4, 32'hA000_0002);
    drop_fetch(32'h8000_0308, RDIR + 32'h8, 2);
    fetch_x(RDIR + 32'h8, 32'hA000_0003);

    mid_reset(32'h8000_0400);
    bus_fetch(32'h8000_0500, 0, 0, 32'h5555_AAAA, 1'b0);
    bus_fetch(32'h8000_0504, 0, 0, 32'h0000_0000, 1'b1);

    repeat (4) tick();
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
